// File: rtl/wave_renderer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wave_renderer_pkg -- FSM state type and pixel colour codes for wave_renderer
// Revision: 1.0
// ----------------------------------------------------------------------------
package wave_renderer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_KEY  = 3'd1,
    RD_SAMP = 3'd2,
    CALC    = 3'd3,
    DRAW    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_KEY   = 3'b010;
  localparam logic [2:0] COL_TRACE = 3'b110;
  localparam logic [2:0] COL_AXIS  = 3'b001;

  // Zero-level row of the waveform: middle of the region below the key bar.
  function automatic int center_row(input int key_bar_h, input int v_res);
    return key_bar_h + (v_res - key_bar_h) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wave_renderer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wave_renderer_if -- control, RAM-read and pixel-plot signals of wave_renderer
// Revision: 1.0
// ----------------------------------------------------------------------------
interface wave_renderer_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic               start;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [DATA_W-1:0]  ram_dout;
  logic               plot;
  logic               plot_ready;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;

  modport master (
    input  start, ram_dout, plot_ready,
    output busy, done, ram_raddr, plot, x, y, color
  );

  modport slave (
    output start, ram_dout, plot_ready,
    input  busy, done, ram_raddr, plot, x, y, color
  );
endinterface
`default_nettype wire

// File: rtl/wave_row_mapper.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wave_row_mapper -- scales a signed sample and maps it to a clamped screen row
// Revision: 1.0
// ----------------------------------------------------------------------------
module wave_row_mapper
  import wave_renderer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int Y_W         = 7,
  parameter int SCALE_SHIFT = 26,
  parameter int KEY_BAR_H   = 16,
  parameter int V_RES       = 120
) (
  input  logic signed [DATA_W-1:0] sample,
  output logic        [Y_W-1:0]    wave_row
);

  localparam int CENTER = center_row(KEY_BAR_H, V_RES);
  localparam logic signed [DATA_W:0] c_center  = $signed((DATA_W+1)'(CENTER));
  localparam logic signed [DATA_W:0] c_row_min = $signed((DATA_W+1)'(KEY_BAR_H));
  localparam logic signed [DATA_W:0] c_row_max = $signed((DATA_W+1)'(V_RES - 1));

  logic signed [DATA_W-1:0] w_shifted;
  logic signed [DATA_W:0]   w_diff;

  // One extra bit keeps CENTER minus the most negative sample from wrapping.
  always_comb begin
    w_shifted = sample >>> SCALE_SHIFT;
    w_diff    = c_center - $signed({w_shifted[DATA_W-1], w_shifted});
    if (w_diff < c_row_min) begin
      wave_row = Y_W'(KEY_BAR_H);
    end else if (w_diff > c_row_max) begin
      wave_row = Y_W'(V_RES - 1);
    end else begin
      wave_row = Y_W'(w_diff);
    end
  end

endmodule
`default_nettype wire

// File: rtl/wave_renderer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wave_renderer -- column-by-column frame renderer: key bar plus sample trace.
// Optional macro WAVE_FILL_EN: fill between centre line and trace row.
// Revision: 1.0
// ----------------------------------------------------------------------------
module wave_renderer
  import wave_renderer_pkg::*;
#(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int COLOR_W     = 3,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_KEYS    = 13,
  parameter int KEY_BASE    = 4,
  parameter int HIST_BASE   = 51,
  parameter int KEY_BAR_H   = 16,
  parameter int SCALE_SHIFT = 26
) (
  input  logic            clk,
  input  logic            reset,
  wave_renderer_if.master bus
);

  localparam int KEY_W  = H_RES / NUM_KEYS;
  localparam int CENTER = center_row(KEY_BAR_H, V_RES);

  state_t                   r_state;
  state_t                   w_next;
  logic [X_W-1:0]           r_x;
  logic [Y_W-1:0]           r_y;
  logic [X_W-1:0]           r_key_col;
  logic [X_W-1:0]           r_key_idx;
  logic                     r_key_on;
  logic signed [DATA_W-1:0] r_sample;
  logic [Y_W-1:0]           w_wave_row;
  logic [ADDR_W-1:0]        w_raddr;
  logic [COLOR_W-1:0]       w_color;
  logic                     w_accept;
  logic                     w_last_row;
  logic                     w_last_col;
  logic                     w_trace;

  assign w_accept   = (r_state == DRAW) && bus.plot_ready;
  assign w_last_row = (r_y == Y_W'(V_RES - 1));
  assign w_last_col = (r_x == X_W'(H_RES - 1));

  wave_row_mapper #(
    .DATA_W      (DATA_W),
    .Y_W         (Y_W),
    .SCALE_SHIFT (SCALE_SHIFT),
    .KEY_BAR_H   (KEY_BAR_H),
    .V_RES       (V_RES)
  ) u_mapper (
    .sample   (r_sample),
    .wave_row (w_wave_row)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_raddr = '0;
    case (r_state)
      IDLE:    if (bus.start) w_next = RD_KEY;
      RD_KEY: begin
        w_raddr = ADDR_W'(KEY_BASE) + ADDR_W'(r_key_idx);
        w_next  = RD_SAMP;
      end
      RD_SAMP: begin
        w_raddr = ADDR_W'(HIST_BASE) + ADDR_W'(r_x);
        w_next  = CALC;
      end
      CALC:    w_next = DRAW;
      DRAW:    if (w_accept && w_last_row) w_next = w_last_col ? DONE : RD_KEY;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // key_col/key_idx track x / KEY_W incrementally so no divider is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x       <= '0;
      r_y       <= '0;
      r_key_col <= '0;
      r_key_idx <= '0;
      r_key_on  <= 1'b0;
      r_sample  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_x       <= '0;
            r_key_col <= '0;
            r_key_idx <= '0;
          end
        end
        RD_SAMP: r_key_on <= (r_key_idx < X_W'(NUM_KEYS)) && (bus.ram_dout != '0);
        CALC: begin
          r_sample <= bus.ram_dout;
          r_y      <= '0;
        end
        DRAW: begin
          if (w_accept) begin
            if (!w_last_row) begin
              r_y <= r_y + 1'b1;
            end else if (!w_last_col) begin
              r_x <= r_x + 1'b1;
              if (r_key_col == X_W'(KEY_W - 1)) begin
                r_key_col <= '0;
                r_key_idx <= r_key_idx + 1'b1;
              end else begin
                r_key_col <= r_key_col + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
`ifdef WAVE_FILL_EN
    if (w_wave_row <= Y_W'(CENTER)) begin
      w_trace = (r_y >= w_wave_row) && (r_y <= Y_W'(CENTER));
    end else begin
      w_trace = (r_y >= Y_W'(CENTER)) && (r_y <= w_wave_row);
    end
`else
    w_trace = (r_y == w_wave_row);
`endif
    w_color = COLOR_W'(COL_BLACK);
    if (r_state == DRAW) begin
      if (r_y < Y_W'(KEY_BAR_H)) begin
        w_color = r_key_on ? COLOR_W'(COL_KEY) : COLOR_W'(COL_BLACK);
      end else if (w_trace) begin
        w_color = COLOR_W'(COL_TRACE);
      end else if (r_y == Y_W'(CENTER)) begin
        w_color = COLOR_W'(COL_AXIS);
      end
    end
  end

  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = (r_state == DONE);
  assign bus.plot      = (r_state == DRAW);
  assign bus.ram_raddr = w_raddr;
  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.color     = w_color;

endmodule
`default_nettype wire

// File: tb/tb_wave_renderer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_wave_renderer -- scoreboard bench: default DUT plus a SCALE_SHIFT=20 DUT
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_wave_renderer;

  localparam int H_RES     = 160;
  localparam int V_RES     = 120;
  localparam int NUM_KEYS  = 13;
  localparam int KEY_W     = 12;
  localparam int KEY_BASE  = 4;
  localparam int HIST_BASE = 51;
  localparam int KEY_BAR_H = 16;
  localparam int CENTER    = 68;
  localparam int NPIX      = H_RES * V_RES;
  // start cycle to done cycle distance; the frame spans this plus one cycle
  localparam int DONE_OFS  = H_RES * (V_RES + 3) + 1;
`ifdef WAVE_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  typedef logic [17:0] pix_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wave_renderer_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .ADDR_W(8), .DATA_W(32)) bus_a ();
  wave_renderer_if #(.X_W(8), .Y_W(7), .COLOR_W(3), .ADDR_W(8), .DATA_W(32)) bus_b ();

  wave_renderer u_dut_a (.clk(clk), .reset(rst), .bus(bus_a));
  wave_renderer #(.SCALE_SHIFT(20)) u_dut_b (.clk(clk), .reset(rst), .bus(bus_b));

  logic [31:0] ram_a [256];
  logic [31:0] ram_b [256];
  always @(posedge clk) begin
    bus_a.ram_dout <= ram_a[bus_a.ram_raddr];
    bus_b.ram_dout <= ram_b[bus_b.ram_raddr];
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pix_t       q_a[$];
  pix_t       q_b[$];
  logic [2:0] cap_a [H_RES][V_RES];
  logic [2:0] cap_b [H_RES][V_RES];
  int acc_a = 0, acc_b = 0, done_a = 0, done_b = 0;
  int done_cyc_a = 0, first_plot_a = -1, stalls_a = 0, start_cyc = 0;
  bit stall_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_row(input logic [31:0] s, input int shift);
    longint v;
    v = longint'($signed(s)) >>> shift;
    v = CENTER - v;
    if (v < KEY_BAR_H) v = KEY_BAR_H;
    if (v > V_RES - 1) v = V_RES - 1;
    return int'(v);
  endfunction

  function automatic logic [2:0] model_color(input int y, input bit key_on, input int wr);
    if (y < KEY_BAR_H) return key_on ? 3'b010 : 3'b000;
    if (FILL ? ((y >= wr && y <= CENTER) || (y <= wr && y >= CENTER)) : (y == wr)) return 3'b110;
    if (y == CENTER) return 3'b001;
    return 3'b000;
  endfunction

  task automatic push_frame(input bit use_b, input int shift);
    for (int xx = 0; xx < H_RES; xx++) begin
      int          ki = xx / KEY_W;
      logic [31:0] kw, sw;
      bit          kon;
      int          wr;
      kw  = use_b ? ram_b[KEY_BASE + ki] : ram_a[KEY_BASE + ki];
      sw  = use_b ? ram_b[HIST_BASE + xx] : ram_a[HIST_BASE + xx];
      kon = (ki < NUM_KEYS) && (kw != 32'd0);
      wr  = model_row(sw, shift);
      for (int yy = 0; yy < V_RES; yy++) begin
        pix_t p;
        p = {8'(xx), 7'(yy), model_color(yy, kon, wr)};
        if (use_b) q_b.push_back(p);
        else       q_a.push_back(p);
      end
    end
  endtask

  task automatic clear_caps();
    for (int i = 0; i < H_RES; i++)
      for (int j = 0; j < V_RES; j++) begin
        cap_a[i][j] = 3'b111;
        cap_b[i][j] = 3'b111;
      end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Output monitor: drives plot_ready, pops the scoreboard on every accept.
  initial begin : monitor
    pix_t cur, held;
    bit   hold_v;
    hold_v = 1'b0;
    bus_b.plot_ready = 1'b1;
    forever begin
      @(negedge clk);
      bus_a.plot_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!rst && bus_a.plot) begin
        cur = {bus_a.x, bus_a.y, bus_a.color};
        if (hold_v) check("stall_hold", 32'(cur), 32'(held));
        if (first_plot_a < 0) first_plot_a = cyc;
        if (bus_a.plot_ready) begin
          hold_v = 1'b0;
          if (q_a.size() == 0) check("a_unexpected_px", q_a.size(), 1);
          else begin
            check("a_pixel", 32'(cur), 32'(q_a.pop_front()));
            if (bus_a.x < H_RES && bus_a.y < V_RES) cap_a[bus_a.x][bus_a.y] = bus_a.color;
            acc_a++;
          end
        end else begin
          hold_v = 1'b1;
          held   = cur;
          stalls_a++;
        end
      end else begin
        hold_v = 1'b0;
      end
      if (!rst && bus_b.plot) begin
        cur = {bus_b.x, bus_b.y, bus_b.color};
        if (q_b.size() == 0) check("b_unexpected_px", q_b.size(), 1);
        else begin
          check("b_pixel", 32'(cur), 32'(q_b.pop_front()));
          if (bus_b.x < H_RES && bus_b.y < V_RES) cap_b[bus_b.x][bus_b.y] = bus_b.color;
          acc_b++;
        end
      end
      if (!rst && bus_a.done) begin
        done_a++;
        done_cyc_a = cyc;
        check("busy_at_done", 32'(bus_a.busy), 32'd1);
      end
      if (!rst && bus_b.done) done_b++;
    end
  end

  task automatic start_frame(input bit with_b);
    bus_a.start = 1'b1;
    bus_b.start = with_b;
    start_cyc   = cyc;
    first_plot_a = -1;
    stalls_a    = 0;
    acc_a       = 0;
    acc_b       = 0;
    check("busy_before_start", 32'(bus_a.busy), 32'd0);
    tick();
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    check("busy_after_start", 32'(bus_a.busy), 32'd1);
  endtask

  task automatic wait_done(input int target_a, input int target_b, input int budget);
    int n = 0;
    while ((done_a < target_a || done_b < target_b) && n < budget) begin
      tick();
      n++;
    end
    check("done_a_seen", done_a, target_a);
    check("done_b_seen", done_b, target_b);
  endtask

  initial begin : main
    int n;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 32'd0;
      ram_b[i] = 32'd0;
    end
    clear_caps();
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    repeat (3) tick();
    check("rst_plot",  32'(bus_a.plot),      32'd0);
    check("rst_busy",  32'(bus_a.busy),      32'd0);
    check("rst_done",  32'(bus_a.done),      32'd0);
    check("rst_xy",    32'({bus_a.x, bus_a.y}), 32'd0);
    check("rst_color", 32'(bus_a.color),     32'd0);
    check("rst_raddr", 32'(bus_a.ram_raddr), 32'd0);
    rst = 1'b0;
    tick();

    // Frame 1: A with all-zero RAM, B (shift 20) with extreme samples
    ram_b[HIST_BASE + 0] = 32'h7FFF_FFFF;
    ram_b[HIST_BASE + 1] = 32'h8000_0000;
    push_frame(1'b0, 26);
    push_frame(1'b1, 20);
    start_frame(1'b1);
    wait_done(1, 1, DONE_OFS + 100);
    check("first_plot_ofs", first_plot_a - start_cyc, 4);
    check("done_ofs",       done_cyc_a - start_cyc, DONE_OFS);
    check("a_pixel_count",  acc_a, NPIX);
    check("b_pixel_count",  acc_b, NPIX);
    check("a_queue_left",   q_a.size(), 0);
    check("b_queue_left",   q_b.size(), 0);
    check("zero_row68",     32'(cap_a[0][68]),  32'd6);
    check("zero_row67",     32'(cap_a[0][67]),  32'd0);
    check("zero_keybar",    32'(cap_a[100][3]), 32'd0);
    check("clamp_top",      32'(cap_b[0][16]),  32'd6);
    check("clamp_bottom",   32'(cap_b[1][119]), 32'd6);
    check("b_zero_col",     32'(cap_b[2][68]),  32'd6);
    tick();
    check("busy_after_done", 32'(bus_a.busy), 32'd0);

    // Frame 2: key 0 pressed, samples in columns 0, 1, 5; reset at x=40
    ram_a[KEY_BASE]       = 32'd1;
    ram_a[HIST_BASE + 0]  = 32'h7FFF_FFFF;
    ram_a[HIST_BASE + 1]  = 32'h8000_0000;
    ram_a[HIST_BASE + 5]  = 32'd10 << 26;
    clear_caps();
    push_frame(1'b0, 26);
    start_frame(1'b0);
    n = 0;
    while (!(bus_a.plot && bus_a.x == 8'd40) && n < 8000) begin
      tick();
      n++;
    end
    check("reach_x40", 32'(bus_a.x), 32'd40);
    rst = 1'b1;
    tick();
    check("mid_rst_plot",  32'(bus_a.plot),  32'd0);
    check("mid_rst_busy",  32'(bus_a.busy),  32'd0);
    check("mid_rst_xy",    32'({bus_a.x, bus_a.y}), 32'd0);
    check("mid_rst_color", 32'(bus_a.color), 32'd0);
    check("mid_rst_raddr", 32'(bus_a.ram_raddr), 32'd0);
    rst = 1'b0;
    q_a.delete();
    check("key_on_px",   32'(cap_a[0][0]),   32'd2);
    check("key_on_edge", 32'(cap_a[11][15]), 32'd2);
    check("key_off_px",  32'(cap_a[12][0]),  32'd0);
    check("col5_row58",  32'(cap_a[5][58]),  32'd6);
    check("col5_row68",  32'(cap_a[5][68]),  FILL ? 32'd6 : 32'd1);
    repeat (5) tick();
    check("no_done_after_rst", done_a, 1);

    // Frame 3: same pattern under random back-pressure, full frame from x=0
    clear_caps();
    push_frame(1'b0, 26);
    stall_en = 1'b1;
    start_frame(1'b0);
    wait_done(2, 1, 3 * DONE_OFS);
    stall_en = 1'b0;
    check("stall_done_ofs", done_cyc_a - start_cyc, DONE_OFS + stalls_a);
    check("stall_px_count", acc_a, NPIX);
    check("stall_q_left",   q_a.size(), 0);
    check("stall_col5_r58", 32'(cap_a[5][58]),   32'd6);
    check("stall_col5_r63", 32'(cap_a[5][63]),   FILL ? 32'd6 : 32'd0);
    check("stall_last_col", 32'(cap_a[159][68]), 32'd6);
    check("stall_unkeyed",  32'(cap_a[156][0]),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
